// File: rtl/adder_checker.sv
// adder_checker: drives an external 3-bit up-counter into a full adder under
// test and checks every applied vector, the adder's sum/carry and the
// counter's overflow flag over PASSES full 8-vector sweeps. It reports an
// error count that stops at 15, and the vector of the first failing sample.
module adder_checker #(
    parameter int PASSES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] vec,
    input  logic       ov,
    input  logic       s,
    input  logic       c1,
    output logic       en,
    output logic       clr,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] first_err_vec,
    output logic       first_err_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index of the final sample; the run leaves RUN after this sample.
    localparam logic [6:0] LAST_K  = 7'(8 * PASSES - 1);
    localparam logic [3:0] ERR_MAX = 4'd15;

    state_t     r_state;
    logic [6:0] r_k;
    logic       r_en;
    logic       r_clr;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err_cnt;
    logic [2:0] r_first_err_vec;
    logic       r_first_err_valid;

    logic       w_s_exp;
    logic       w_c1_exp;
    logic       w_ov_checked;
    logic       w_ov_exp;
    logic       w_fail;
    logic [3:0] w_err_next;

    // Expected response for the current sample index and the pass/fail verdict.
    always_comb begin
        // NOTE: every signal gets a value on every path through this block,
        // otherwise synthesis would infer a latch to hold the old value.
        w_s_exp      = vec[0] ^ vec[1] ^ vec[2];
        w_c1_exp     = (vec[0] & vec[1]) | (vec[0] & vec[2]) | (vec[1] & vec[2]);
        // At k == 0 the counter has just been cleared, so its flag means nothing.
        w_ov_checked = (r_k != 7'd0);
        w_ov_exp     = (r_k[2:0] == 3'd0);
        w_fail       = (vec != r_k[2:0])
                     | (s != w_s_exp)
                     | (c1 != w_c1_exp)
                     | (w_ov_checked & (ov != w_ov_exp));
        w_err_next   = r_err_cnt;
        if (w_fail && (r_err_cnt != ERR_MAX)) begin
            w_err_next = r_err_cnt + 4'd1;
        end
    end

    // Control FSM with registered outputs and the result registers it owns.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, which matches real flops.
        if (!reset) begin
            r_state           <= IDLE;
            r_k               <= 7'd0;
            r_en              <= 1'b0;
            r_clr             <= 1'b0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_cnt         <= 4'd0;
            r_first_err_vec   <= 3'd0;
            r_first_err_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        // Results are wiped on entry so CLEAR already shows a blank run.
                        r_state           <= CLEAR;
                        r_clr             <= 1'b1;
                        r_en              <= 1'b0;
                        r_busy            <= 1'b1;
                        r_done            <= 1'b0;
                        r_pass            <= 1'b0;
                        r_k               <= 7'd0;
                        r_err_cnt         <= 4'd0;
                        r_first_err_vec   <= 3'd0;
                        r_first_err_valid <= 1'b0;
                    end
                end
                CLEAR: begin
                    r_state <= RUN;
                    r_clr   <= 1'b0;
                    r_en    <= 1'b1;
                    r_k     <= 7'd0;
                end
                RUN: begin
                    r_k       <= r_k + 7'd1;
                    r_err_cnt <= w_err_next;
                    if (w_fail && !r_first_err_valid) begin
                        r_first_err_vec   <= vec;
                        r_first_err_valid <= 1'b1;
                    end
                    if (r_k == LAST_K) begin
                        r_state <= DONE;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        // The final sample may still fail, so judge the updated count.
                        r_pass  <= (w_err_next == 4'd0);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_en    <= 1'b0;
                    r_clr   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign en              = r_en;
    assign clr             = r_clr;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_cnt         = r_err_cnt;
    assign first_err_vec   = r_first_err_vec;
    assign first_err_valid = r_first_err_valid;

endmodule

// File: doc/adder_checker.md
ADDER_CHECKER -- requirements
Module: adder_checker

Interface
REQ-001 Parameter: PASSES, 1, number of full 8-vector sweeps per run (legal 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle run request; honoured only in IDLE or DONE.
REQ-005 vec  input  3  applied vector from the up-counter ({c0,a1,a0} = vec[2:0]).
REQ-006 ov  input  1  counter overflow flag.
REQ-007 s  input  1  full-adder sum under test.
REQ-008 c1  input  1  full-adder carry under test.
REQ-009 en  output  1  counter enable drive.
REQ-010 clr  output  1  counter clear drive.
REQ-011 busy  output  1  high in CLEAR and RUN.
REQ-012 done  output  1  high in DONE.
REQ-013 pass  output  1  high in DONE when err_cnt == 0; low elsewhere.
REQ-014 err_cnt  output  4  number of failing sample cycles, saturating.
REQ-015 first_err_vec  output  3  vec sampled on the first failing cycle of the run.
REQ-016 first_err_valid  output  1  first_err_vec holds a captured value.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, RUN, DONE, registered.
REQ-018 IDLE: en=0, clr=0; start=1 -> CLEAR next edge.
REQ-019 CLEAR: lasts exactly 1 cycle; clr=1, en=0; clears err_cnt, first_err_valid, first_err_vec, sample index k; -> RUN.
REQ-020 RUN: en=1, clr=0; one sample per cycle of vec, s, c1, ov; lasts exactly 8*PASSES cycles; -> DONE after last sample.
REQ-021 Sample index k SHALL start at 0 in the first RUN cycle and increment by 1 per RUN cycle; width 7 bits.
REQ-022 Expected values per sample: vec_exp = k[2:0]; s_exp = vec[0]^vec[1]^vec[2]; c1_exp = majority(vec[0],vec[1],vec[2]).
REQ-023 Expected ov: 1 when k != 0 and k[2:0] == 0; 0 when k[2:0] != 0; ov not checked at k == 0.
REQ-024 A sample cycle SHALL fail if any of vec != vec_exp, s != s_exp, c1 != c1_exp, or a checked ov mismatches; at most one count per cycle.
REQ-025 On a failing cycle err_cnt SHALL increment by 1, holding at 15 (no wrap).
REQ-026 On the first failing cycle of a run, first_err_vec <= vec and first_err_valid <= 1 on the same edge; later failures SHALL NOT overwrite.
REQ-027 err_cnt, first_err_vec, first_err_valid visible one cycle after the failing sample and held through DONE.
REQ-028 DONE: en=0, clr=0, done=1, pass=(err_cnt==0); holds until start=1 -> CLEAR (new run).
REQ-029 start in CLEAR or RUN SHALL be ignored; run not restarted.
REQ-030 All outputs SHALL be registered or decoded from registered state only; no combinational path from s, c1, vec, ov to outputs.

Reset
REQ-031 reset=0 at a rising edge SHALL force IDLE, en=0, clr=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vec=0, first_err_valid=0, k=0.
REQ-032 Reset SHALL take priority over start and over any state, including mid-RUN; an aborted run leaves no result.
REQ-033 start asserted while reset=0 SHALL be ignored.

Verification
REQ-034 PASSES=1, correct adder, counter preset to 5: start -> clr high 1 cycle, 8 RUN cycles see vec 0..7, done=1, pass=1, err_cnt=0, first_err_valid=0.
REQ-035 PASSES=2, correct adder: 16 RUN cycles, ov=1 at k=8 accepted, pass=1; force ov=0 at k=8 -> err_cnt=1, first_err_vec=0.
REQ-036 Inject s stuck-at-0: failures at vec 1,2,4,7 -> err_cnt=4, first_err_vec=1, pass=0.
REQ-037 PASSES=3, c1 inverted every cycle: 24 failures -> err_cnt saturates at 15, first_err_vec=0.
REQ-038 Counter held (EN ignored) at 0: vec_exp mismatch k=1..7 -> err_cnt=7, first_err_vec=0 captured at k=1.
REQ-039 reset=0 at RUN k=4 -> next edge IDLE, all outputs 0; start afterwards -> clean run, pass=1; start during RUN ignored.
